// File: rtl/aes_block_packer.sv
// Word/block adapter between the HWPE streamers and the AES core: gathers plaintext
// words into cipher blocks, scatters ciphertext blocks into words, and counts finished blocks.
//
// state | meaning
// IDLE  | waiting for start_i, counters hold the last job's result
// RUN   | gather and scatter paths active until the last block is written out
// DONE  | single-cycle completion pulse, then back to IDLE
module aes_block_packer #(
  parameter int DATA_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_i,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   num_blocks_i,
  input  logic               in_valid_i,
  input  logic [DATA_W-1:0]  in_data_i,
  output logic               in_ready_o,
  output logic               blk_valid_o,
  output logic [BLOCK_W-1:0] blk_data_o,
  input  logic               blk_ready_i,
  input  logic               res_valid_i,
  input  logic [BLOCK_W-1:0] res_data_i,
  output logic               res_ready_o,
  output logic               out_valid_o,
  output logic [DATA_W-1:0]  out_data_o,
  input  logic               out_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   blk_cnt_o
);

  localparam int WORDS = BLOCK_W / DATA_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     num_blocks_q;
  logic [CNT_W-1:0]     blk_issued;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic                 blk_full;
  logic                 res_full;
  logic [BLOCK_W-1:0]   res_buf;
  logic                 start_load;
  logic                 in_hs;
  logic                 blk_hs;
  logic                 res_hs;
  logic                 out_hs;
  logic                 last_word;
  logic                 last_block;

  assign start_load = (state == ST_IDLE) && start_i;
  assign in_hs      = in_valid_i && in_ready_o;
  assign blk_hs     = blk_valid_o && blk_ready_i;
  assign res_hs     = res_valid_i && res_ready_o;
  assign out_hs     = out_valid_o && out_ready_i;
  assign last_word  = (rd_idx == LAST_IDX);
  assign last_block = (blk_cnt_o == (num_blocks_q - CNT_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else if (clear_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    in_ready_o  = 1'b0;
    res_ready_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt = (num_blocks_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy_o      = 1'b1;
        in_ready_o  = !blk_full && (blk_issued < num_blocks_q);
        res_ready_o = !res_full;
        if (out_hs && last_word && last_block) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_o    = 1'b1;
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake pairs on each path are mutually exclusive through the full flags,
  // so gather and scatter updates never collide on the same register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_blocks_q <= '0;
      blk_issued   <= '0;
      blk_cnt_o    <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      blk_full     <= 1'b0;
      res_full     <= 1'b0;
      blk_data_o   <= '0;
      res_buf      <= '0;
    end else if (clear_i) begin
      num_blocks_q <= '0;
      blk_issued   <= '0;
      blk_cnt_o    <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      blk_full     <= 1'b0;
      res_full     <= 1'b0;
      blk_data_o   <= '0;
      res_buf      <= '0;
    end else if (start_load) begin
      num_blocks_q <= num_blocks_i;
      blk_issued   <= '0;
      blk_cnt_o    <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      blk_full     <= 1'b0;
      res_full     <= 1'b0;
    end else begin
      if (in_hs) begin
        for (int i = 0; i < WORDS; i++) begin
          if (wr_idx == IDX_W'(i)) begin
            blk_data_o[BLOCK_W-1-i*DATA_W -: DATA_W] <= in_data_i;
          end
        end
        if (wr_idx == LAST_IDX) begin
          wr_idx     <= '0;
          blk_full   <= 1'b1;
          blk_issued <= blk_issued + CNT_W'(1);
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
      if (blk_hs) begin
        blk_full <= 1'b0;
      end

      if (res_hs) begin
        res_buf  <= res_data_i;
        res_full <= 1'b1;
        rd_idx   <= '0;
      end else if (out_hs) begin
        if (last_word) begin
          rd_idx    <= '0;
          res_full  <= 1'b0;
          blk_cnt_o <= blk_cnt_o + CNT_W'(1);
        end else begin
          rd_idx <= rd_idx + IDX_W'(1);
        end
      end
    end
  end

  assign blk_valid_o = blk_full;
  assign out_valid_o = res_full;

  always_comb begin
    out_data_o = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        out_data_o = res_buf[BLOCK_W-1-i*DATA_W -: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: directed AES-vector job plus randomized
// jobs against a word-queue reference model with an echoing core.
module tb_aes_block_packer;
  localparam int DATA_W  = 32;
  localparam int BLOCK_W = 128;
  localparam int CNT_W   = 16;
  localparam int WORDS   = BLOCK_W / DATA_W;
  localparam int OUTS_W  = 1 + 1 + BLOCK_W + 1 + 1 + DATA_W + 1 + 1 + CNT_W;

  logic               clk;
  logic               reset_n;
  logic               clear_i;
  logic               start_i;
  logic [CNT_W-1:0]   num_blocks_i;
  logic               in_valid_i;
  logic [DATA_W-1:0]  in_data_i;
  logic               in_ready_o;
  logic               blk_valid_o;
  logic [BLOCK_W-1:0] blk_data_o;
  logic               blk_ready_i;
  logic               res_valid_i;
  logic [BLOCK_W-1:0] res_data_i;
  logic               res_ready_o;
  logic               out_valid_o;
  logic [DATA_W-1:0]  out_data_o;
  logic               out_ready_i;
  logic               busy_o;
  logic               done_o;
  logic [CNT_W-1:0]   blk_cnt_o;

  int checks = 0;
  int errors = 0;

  aes_block_packer #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .start_i(start_i),
    .num_blocks_i(num_blocks_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .blk_valid_o(blk_valid_o), .blk_data_o(blk_data_o),
    .blk_ready_i(blk_ready_i), .res_valid_i(res_valid_i), .res_data_i(res_data_i),
    .res_ready_o(res_ready_o), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o), .blk_cnt_o(blk_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUTS_W-1:0] outs_vec();
    return {in_ready_o, blk_valid_o, blk_data_o, res_ready_o, out_valid_o,
            out_data_o, busy_o, done_o, blk_cnt_o};
  endfunction

  task automatic idle_inputs();
    start_i = 1'b0; num_blocks_i = '0; in_valid_i = 1'b0; in_data_i = '0;
    blk_ready_i = 1'b0; res_valid_i = 1'b0; res_data_i = '0; out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear_i = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs_vec() !== '0) begin errors++; $display("FAIL reset_outputs: got %0h expected 0", outs_vec()); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %0b expected 0", busy_o); end
  endtask

  task automatic test_single_block();
    logic [DATA_W-1:0]  w [WORDS] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    logic [DATA_W-1:0]  r [WORDS] = '{32'h69C4E0D8, 32'h6A7B0430, 32'hD8CDB780, 32'h70B4C55A};
    logic [BLOCK_W-1:0] exp_blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [BLOCK_W-1:0] res_blk = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
    @(negedge clk);
    start_i = 1'b1; num_blocks_i = 16'd1; blk_ready_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; num_blocks_i = '0;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL sb_busy: got %0b expected 1", busy_o); end
    for (int i = 0; i < WORDS; i++) begin
      in_valid_i = 1'b1; in_data_i = w[i];
      checks++;
      if (in_ready_o !== 1'b1 || blk_valid_o !== 1'b0) begin
        errors++; $display("FAIL sb_gather word %0d: in_ready %0b blk_valid %0b expected 1 0", i, in_ready_o, blk_valid_o);
      end
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    checks++;
    if (blk_valid_o !== 1'b1 || blk_data_o !== exp_blk) begin
      errors++; $display("FAIL sb_block: valid %0b data %0h expected 1 %0h", blk_valid_o, blk_data_o, exp_blk);
    end
    @(negedge clk);
    checks++;
    if (blk_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin
      errors++; $display("FAIL sb_after_blk: blk_valid %0b in_ready %0b expected 0 0", blk_valid_o, in_ready_o);
    end
    res_valid_i = 1'b1; res_data_i = res_blk;
    checks++;
    if (res_ready_o !== 1'b1) begin errors++; $display("FAIL sb_res_ready: got %0b expected 1", res_ready_o); end
    @(negedge clk);
    res_valid_i = 1'b0; res_data_i = '0;
    for (int i = 0; i < WORDS; i++) begin
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== r[i]) begin
        errors++; $display("FAIL sb_out word %0d: valid %0b data %0h expected 1 %0h", i, out_valid_o, out_data_o, r[i]);
      end
      @(negedge clk);
    end
    out_ready_i = 1'b0; blk_ready_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || blk_cnt_o !== 16'd1 || out_valid_o !== 1'b0) begin
      errors++; $display("FAIL sb_done: done %0b cnt %0d out_valid %0b expected 1 1 0", done_o, blk_cnt_o, out_valid_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || blk_cnt_o !== 16'd1) begin
      errors++; $display("FAIL sb_idle: done %0b busy %0b cnt %0d expected 0 0 1", done_o, busy_o, blk_cnt_o);
    end
  endtask

  task automatic test_zero_blocks();
    @(negedge clk);
    start_i = 1'b1; num_blocks_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b1 || in_ready_o !== 1'b0 || res_ready_o !== 1'b0 || blk_cnt_o !== '0) begin
      errors++; $display("FAIL zero_done_cycle: busy %0b done %0b in_rdy %0b res_rdy %0b cnt %0d expected 1 1 0 0 0",
                         busy_o, done_o, in_ready_o, res_ready_o, blk_cnt_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || in_ready_o !== 1'b0 || res_ready_o !== 1'b0) begin
      errors++; $display("FAIL zero_after: busy %0b done %0b in_rdy %0b res_rdy %0b expected 0 0 0 0",
                         busy_o, done_o, in_ready_o, res_ready_o);
    end
  endtask

  // Randomized job: words go in, the core echoes blocks, words must come out in order.
  task automatic run_job(input int n, input int stall, input bit poke_start, input string tag);
    logic [DATA_W-1:0]  w[$];
    logic [BLOCK_W-1:0] core_q[$];
    logic [BLOCK_W-1:0] exp_blk;
    logic [BLOCK_W-1:0] prev_blk;
    logic [DATA_W-1:0]  prev_out;
    bit stall_blk, stall_out, expect_done, fin;
    int n_in, n_blk, n_out, n_done, cyc;
    n_in = 0; n_blk = 0; n_out = 0; n_done = 0; cyc = 0;
    stall_blk = 0; stall_out = 0; expect_done = 0; fin = 0;
    prev_blk = '0; prev_out = '0;
    for (int i = 0; i < WORDS * n + 2; i++) w.push_back($urandom);
    @(negedge clk);
    start_i = 1'b1; num_blocks_i = CNT_W'(n);
    @(negedge clk);
    start_i = 1'b0; num_blocks_i = '0;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL %s busy_start: got %0b expected 1", tag, busy_o); end
    while (!fin) begin
      if (stall_blk) begin
        checks++;
        if (blk_valid_o !== 1'b1 || blk_data_o !== prev_blk) begin
          errors++; $display("FAIL %s blk_stable: valid %0b data %0h expected 1 %0h", tag, blk_valid_o, blk_data_o, prev_blk);
        end
      end
      if (stall_out) begin
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== prev_out) begin
          errors++; $display("FAIL %s out_stable: valid %0b data %0h expected 1 %0h", tag, out_valid_o, out_data_o, prev_out);
        end
      end
      if (blk_valid_o === 1'b1) begin
        checks++;
        if (in_ready_o !== 1'b0) begin errors++; $display("FAIL %s in_ready_full: got %0b expected 0", tag, in_ready_o); end
      end
      checks++;
      if (done_o !== expect_done) begin errors++; $display("FAIL %s done_timing: got %0b expected %0b", tag, done_o, expect_done); end
      if (done_o === 1'b1) n_done++;
      if (expect_done) fin = 1;
      if (cyc >= 3000) begin
        errors++; $display("FAIL %s timeout: words out %0d expected %0d", tag, n_out, WORDS * n);
        fin = 1;
      end
      if (!fin) begin
        in_valid_i = ($urandom_range(99) >= 20);
        in_data_i  = (n_in < w.size()) ? w[n_in] : '0;
        if (in_valid_i && in_ready_o) begin
          checks++;
          if (n_in >= WORDS * n) begin errors++; $display("FAIL %s extra_word: accepted %0d expected max %0d", tag, n_in + 1, WORDS * n); end
          n_in++;
        end
        blk_ready_i = ($urandom_range(99) >= stall);
        if (blk_valid_o && blk_ready_i) begin
          exp_blk = '0;
          if (n_blk < n) for (int k = 0; k < WORDS; k++) exp_blk = {exp_blk[BLOCK_W-DATA_W-1:0], w[WORDS * n_blk + k]};
          checks++;
          if (n_blk >= n || blk_data_o !== exp_blk) begin
            errors++; $display("FAIL %s block %0d: got %0h expected %0h", tag, n_blk, blk_data_o, exp_blk);
          end
          core_q.push_back(blk_data_o);
          n_blk++;
        end
        res_valid_i = (core_q.size() > 0) && ($urandom_range(99) >= stall);
        res_data_i  = res_valid_i ? core_q[0] : '0;
        if (res_valid_i && res_ready_o) void'(core_q.pop_front());
        out_ready_i = ($urandom_range(99) >= stall);
        if (out_valid_o && out_ready_i) begin
          checks++;
          if (n_out >= WORDS * n || out_data_o !== w[n_out]) begin
            errors++; $display("FAIL %s out_word %0d: got %0h expected %0h", tag, n_out, out_data_o,
                               (n_out < w.size()) ? w[n_out] : '0);
          end
          n_out++;
          if (n_out == WORDS * n) expect_done = 1;
        end
        stall_blk = blk_valid_o && !blk_ready_i;
        stall_out = out_valid_o && !out_ready_i;
        prev_blk  = blk_data_o;
        prev_out  = out_data_o;
        start_i      = poke_start && (cyc == 6);
        num_blocks_i = start_i ? 16'd5 : '0;
        @(negedge clk);
        cyc++;
      end
    end
    idle_inputs();
    checks++;
    if (n_done != 1 || n_in != WORDS * n || n_out != WORDS * n || blk_cnt_o !== CNT_W'(n)) begin
      errors++; $display("FAIL %s job_totals: done %0d in %0d out %0d cnt %0d expected 1 %0d %0d %0d",
                         tag, n_done, n_in, n_out, blk_cnt_o, WORDS * n, WORDS * n, n);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || blk_cnt_o !== CNT_W'(n)) begin
        errors++; $display("FAIL %s after_job: done %0b busy %0b cnt %0d expected 0 0 %0d", tag, done_o, busy_o, blk_cnt_o, n);
      end
    end
  endtask

  task automatic test_backpressure();
    run_job(3, 40, 1'b0, "bp");
  endtask

  task automatic test_clear_mid_job();
    @(negedge clk);
    start_i = 1'b1; num_blocks_i = 16'd2;
    @(negedge clk);
    start_i = 1'b0; num_blocks_i = '0;
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'b1; in_data_i = $urandom;
      @(negedge clk);
    end
    in_valid_i = 1'b0; clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    checks++;
    if (outs_vec() !== '0) begin errors++; $display("FAIL clear_outputs: got %0h expected 0", outs_vec()); end
    run_job(1, 30, 1'b0, "clr");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start_i = 1'b1; num_blocks_i = 16'd1; blk_ready_i = 1'b1; out_ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0; num_blocks_i = '0;
    for (int i = 0; i < WORDS; i++) begin
      in_valid_i = 1'b1; in_data_i = $urandom;
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    @(negedge clk);
    blk_ready_i = 1'b0; res_valid_i = 1'b1; res_data_i = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    res_valid_i = 1'b0; out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b1) begin errors++; $display("FAIL ar_mid_block: out_valid %0b expected 1", out_valid_o); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (outs_vec() !== '0) begin errors++; $display("FAIL ar_async_outputs: got %0h expected 0", outs_vec()); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL ar_in_reset: done %0b busy %0b expected 0 0", done_o, busy_o); end
    end
    reset_n = 1'b1;
    idle_inputs();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL ar_after: done %0b busy %0b expected 0 0", done_o, busy_o); end
    end
  endtask

  task automatic test_start_ignored();
    run_job(2, 25, 1'b1, "sti");
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_zero_blocks();
    test_backpressure();
    test_clear_mid_job();
    test_async_reset();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
